// File: rtl/riscv_cpu.sv
// riscv_cpu: single-cycle RV32I execute core.
// Decode, register file (r), ALU and PC (p).
package riscv_pkg;
  typedef struct packed {
    logic        is_r;
    logic        is_i;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
  } dec_t;
endpackage

module riscv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] reg_mem [32];

  assign rdata1 = (rs1 == 5'd0) ? '0 : reg_mem[rs1];
  assign rdata2 = (rs2 == 5'd0) ? '0 : reg_mem[rs2];

  // Clear all registers on reset; x0 writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        reg_mem[i] <= '0;
    end else if (we && rd != 5'd0) begin
      reg_mem[rd] <= wdata;
    end
  end
endmodule

module riscv_pc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] next_pc,
  output logic [31:0] pc
);
  logic [31:0] pc_counter;

  assign pc = pc_counter;

  // PC advances only on executed instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_counter <= '0;
    else if (en)
      pc_counter <= next_pc;
  end
endmodule

module riscv_cpu
  import riscv_pkg::*;
(
  input logic        cpu_clk,
  input logic        cpu_rst,
  input logic [31:0] cpu_instruction,
  input logic        cpu_instruction_RDY_BSY
);
  dec_t        dec;
  logic [31:0] w;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic [31:0] op_b;
  logic [4:0]  sh;
  logic [31:0] alu_y;
  logic        lt_s;
  logic        lt_u;
  logic        take;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] next_pc;

  assign w = cpu_instruction;

  // Field extraction and immediate formation.
  always_comb begin
    dec         = '0;
    dec.is_r    = w[6:0] == 7'b0110011;
    dec.is_i    = w[6:0] == 7'b0010011;
    dec.is_br   = w[6:0] == 7'b1100011;
    dec.is_jal  = w[6:0] == 7'b1101111;
    dec.is_jalr = w[6:0] == 7'b1100111;
    dec.rd      = w[11:7];
    dec.f3      = w[14:12];
    dec.rs1     = w[19:15];
    dec.rs2     = w[24:20];
    dec.alt     = w[30];
    dec.imm_i   = {{20{w[31]}}, w[31:20]};
    dec.imm_b   = {{19{w[31]}}, w[31], w[7],
                   w[30:25], w[11:8], 1'b0};
    dec.imm_j   = {{11{w[31]}}, w[31], w[19:12],
                   w[20], w[30:21], 1'b0};
  end

  riscv_regfile r (
    .clk    (cpu_clk),
    .rst_n  (cpu_rst),
    .we     (wen && cpu_instruction_RDY_BSY),
    .rd     (dec.rd),
    .wdata  (wdata),
    .rs1    (dec.rs1),
    .rs2    (dec.rs2),
    .rdata1 (rs1_v),
    .rdata2 (rs2_v)
  );

  riscv_pc p (
    .clk     (cpu_clk),
    .rst_n   (cpu_rst),
    .en      (cpu_instruction_RDY_BSY),
    .next_pc (next_pc),
    .pc      (pc)
  );

  assign op_b = dec.is_r ? rs2_v : dec.imm_i;
  assign sh   = op_b[4:0];

  // ALU shared by R-type and I-type; only R-type subtracts.
  always_comb begin
    alu_y = '0;
    case (dec.f3)
      3'b000: alu_y = (dec.is_r && dec.alt) ?
                      rs1_v - op_b : rs1_v + op_b;
      3'b001: alu_y = rs1_v << sh;
      3'b010: alu_y = {31'd0,
                       $signed(rs1_v) < $signed(op_b)};
      3'b011: alu_y = {31'd0, rs1_v < op_b};
      3'b100: alu_y = rs1_v ^ op_b;
      3'b101: alu_y = dec.alt ?
                      $unsigned($signed(rs1_v) >>> sh) :
                      rs1_v >> sh;
      3'b110: alu_y = rs1_v | op_b;
      default: alu_y = rs1_v & op_b;
    endcase
  end

  assign lt_s = $signed(rs1_v) < $signed(rs2_v);
  assign lt_u = rs1_v < rs2_v;

  // Branch condition; 010/011 never take.
  always_comb begin
    take = 1'b0;
    case (dec.f3)
      3'b000: take = rs1_v == rs2_v;
      3'b001: take = rs1_v != rs2_v;
      3'b100: take = lt_s;
      3'b101: take = !lt_s;
      3'b110: take = lt_u;
      3'b111: take = !lt_u;
      default: take = 1'b0;
    endcase
  end

  assign pc4 = pc + 32'd4;

  // Writeback select and next-PC select.
  always_comb begin
    wen     = 1'b0;
    wdata   = alu_y;
    next_pc = pc4;
    unique case (1'b1)
      dec.is_r, dec.is_i: wen = 1'b1;
      dec.is_jal: begin
        wen     = 1'b1;
        wdata   = pc4;
        next_pc = pc + dec.imm_j;
      end
      dec.is_jalr: begin
        wen     = 1'b1;
        wdata   = pc4;
        next_pc = (rs1_v + dec.imm_i) & ~32'd1;
      end
      dec.is_br: if (take) next_pc = pc + dec.imm_b;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_riscv_cpu.sv
// tb_riscv_cpu: directed scoreboard bench.
// Expectations queued per step, drained after each edge.
module tb_riscv_cpu;
  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        vld;

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  riscv_cpu dut (
    .cpu_clk                 (clk),
    .cpu_rst                 (rst),
    .cpu_instruction         (instr),
    .cpu_instruction_RDY_BSY (vld)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_JR = 7'b1100111;

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'b1101111};
  endfunction

  task automatic exp_reg(input string t, input int i,
                         input logic [31:0] v);
    exp_t e;
    e.tag = t; e.idx = i; e.val = v;
    q.push_back(e);
  endtask

  task automatic exp_pc(input string t,
                        input logic [31:0] v);
    exp_reg(t, -1, v);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.idx < 0) obs = dut.p.pc_counter;
      else obs = dut.r.reg_mem[e.idx];
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s got=%h exp=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input logic [31:0] w,
                      input logic v, input int n);
    @(negedge clk);
    instr = w;
    vld   = v;
    repeat (n) @(posedge clk);
    #1;
    vld = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b0; vld = 1'b0; instr = '0;
    #2;
    exp_pc("rst_pc", 0);
    exp_reg("rst_x1", 1, 0);
    exp_reg("rst_x31", 31, 0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    exp_reg("addi_x1", 1, 5); exp_pc("pc4", 4);
    step(enc_i(12'd5, 0, 0, 1, OP_I), 1, 1);
    exp_reg("addi_x2", 2, 10); exp_pc("pc8", 8);
    step(enc_i(12'd5, 1, 0, 2, OP_I), 1, 1);
    exp_reg("add_x3", 3, 15); exp_reg("x0", 0, 0);
    exp_pc("pc12", 12);
    step(enc_r(7'h00, 2, 1, 0, 3), 1, 1);
    exp_reg("and_f7", 4, 32'hA); exp_pc("pc16", 16);
    step(enc_r(7'h20, 3, 2, 3'b111, 4), 1, 1);

    exp_pc("beq_t", 18);
    step(enc_b(13'd2, 4, 2, 3'b000), 1, 1);
    exp_pc("bne_t", 22);
    step(enc_b(13'd4, 4, 0, 3'b001), 1, 1);
    exp_pc("blt_t", 24);
    step(enc_b(13'd2, 4, 0, 3'b100), 1, 1);
    exp_pc("bge_t", 28);
    step(enc_b(13'd4, 0, 4, 3'b101), 1, 1);
    exp_pc("bltu_nt", 32);
    step(enc_b(13'd4, 0, 4, 3'b110), 1, 1);
    exp_pc("bne_nt", 36);
    step(enc_b(13'd8, 4, 2, 3'b001), 1, 1);
    exp_pc("br010_nt", 40);
    step(enc_b(13'd8, 0, 0, 3'b010), 1, 1);

    exp_reg("sub", 5, 10); exp_pc("pc44", 44);
    step(enc_r(7'h20, 1, 3, 0, 5), 1, 1);
    exp_reg("addi_neg", 6, 32'hFFFF_FFFF);
    step(enc_i(12'hFFF, 0, 0, 6, OP_I), 1, 1);
    exp_reg("slt", 7, 1);
    step(enc_r(7'h00, 0, 6, 3'b010, 7), 1, 1);
    exp_reg("sltu", 10, 1);
    step(enc_r(7'h00, 6, 0, 3'b011, 10), 1, 1);
    exp_reg("srai", 11, 32'hFFFF_FFFF);
    step(enc_i(12'h404, 6, 3'b101, 11, OP_I), 1, 1);
    exp_reg("srli", 12, 32'h0000_000F);
    exp_pc("pc64", 64);
    step(enc_i(12'd28, 6, 3'b101, 12, OP_I), 1, 1);
    exp_pc("blt_back", 56);
    step(enc_b(13'h1FF8, 0, 6, 3'b100), 1, 1);
    exp_pc("bgeu_t", 68);
    step(enc_b(13'd12, 0, 6, 3'b111), 1, 1);

    exp_reg("jal_rd", 8, 72); exp_pc("jal_pc", 102);
    step(enc_j(21'd34, 8), 1, 1);
    exp_reg("jalr_rd", 9, 106); exp_pc("jalr_pc", 10);
    step(enc_i(12'd5, 1, 0, 9, OP_JR), 1, 1);
    exp_reg("jalr_self", 1, 14); exp_pc("jalr_s_pc", 4);
    step(enc_i(12'd0, 1, 0, 1, OP_JR), 1, 1);

    exp_pc("hold_pc", 4); exp_reg("hold_x13", 13, 0);
    step(enc_i(12'd99, 0, 0, 13, OP_I), 0, 4);
    exp_reg("load_nw", 14, 0); exp_pc("load_pc", 8);
    step(enc_i(12'd0, 0, 3'b010, 14, 7'b0000011), 1, 1);
    exp_reg("lui_nw", 15, 0); exp_pc("lui_pc", 12);
    step({20'hABCDE, 5'd15, 7'b0110111}, 1, 1);
    exp_reg("x0_wr", 0, 0); exp_pc("pc16b", 16);
    step(enc_i(12'd7, 0, 0, 0, OP_I), 1, 1);
    exp_reg("rep_x16", 16, 1); exp_pc("rep_pc", 28);
    step(enc_i(12'd1, 0, 0, 16, OP_I), 1, 3);

    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    exp_pc("mrst_pc", 0);
    for (int i = 0; i < 32; i++)
      exp_reg($sformatf("mrst_x%0d", i), i, 0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    exp_reg("post_rst", 1, 3); exp_pc("post_pc", 4);
    step(enc_i(12'd3, 0, 0, 1, OP_I), 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_cpu.md
# riscv_cpu

Single-cycle RV32I integer execution core without instruction fetch. An external agent presents one 32-bit instruction word per cycle together with a valid flag. The core decodes and executes the word and updates its program counter and 32-entry register file. It contains decode, register file (instance `r`), ALU and program counter (instance `p`). It has no outputs; verification observes `r.reg_mem[0..31]` and `p.pc_counter` hierarchically.

## Interface
- No parameters (XLEN fixed at 32, 32 registers).
- `cpu_clk` input 1: sole clock; all state updates on rising edge.
- `cpu_rst` input 1: asynchronous, active-low reset.
- `cpu_instruction` input 32: RV32I instruction word to execute.
- `cpu_instruction_RDY_BSY` input 1: 1 = `cpu_instruction` is valid and is executed at the next rising edge; 0 = hold all state.

## Operation
- Decode uses opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20] and funct7 [31:25].
- Reads are combinational from `reg_mem`. Writeback and the PC update occur on the same edge.
- `x0` reads 0 always, and writes to it are discarded.
- R-type (0110011):
  - ADD/SUB on funct3 000: `inst[30]`=1 selects SUB.
  - SLL 001, SLT 010 (signed), SLTU 011 (unsigned) → 1/0.
  - XOR 100; SRL/SRA on 101, with `inst[30]` selecting SRA; OR 110; AND 111.
  - funct7 is ignored for all funct3 other than 000 and 101. An AND encoded with funct7=0100000 is still AND.
  - Shift amount is `rs2[4:0]`.
- I-type ALU (0010011):
  - Same funct3 map as R-type, with operand B = sign-extended imm[31:20].
  - Always add, never subtract, on funct3 000.
  - Shifts use imm[4:0]; `inst[30]` selects SRAI on funct3 101.
- Branch (1100011):
  - imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), a byte offset.
  - BEQ 000, BNE 001, BLT 100, BGE 101 (signed), BLTU 110, BGEU 111 (unsigned).
  - Taken: PC ← PC + imm. Not taken: PC ← PC + 4.
  - funct3 010/011 behave as not-taken.
- JAL (1101111):
  - rd ← PC+4.
  - PC ← PC + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- JALR (1100111):
  - rd ← PC+4.
  - PC ← (rs1 + sext(imm[31:20])) & ~1, computed from the pre-write rs1 value.
- Load (0000011), store (0100011), LUI, AUIPC, SYSTEM and any unknown opcode: no register write, PC ← PC+4. There is no data memory.
- All arithmetic is modulo 2^32; overflow is ignored. PC wraps modulo 2^32.

## Timing
- Reset (`cpu_rst`=0), asynchronous:
  - `pc_counter` = 0 and all `reg_mem` = 0 immediately.
  - Held while low; no execution.
- Normal operation: latency is one edge. Results and the new PC are visible after the rising edge on which `cpu_instruction_RDY_BSY`=1.
- If the same word is held valid for N edges, it executes N times. ALU ops whose rd ≠ rs are idempotent in the register file, but PC advances each edge.
- Valid=0 at an edge: PC and registers unchanged.
- rd == rs1/rs2: sources are the pre-edge values.
- Reset asserted mid-operation overrides any concurrent write.

## Test plan
- Reset, then `addi x1,x0,5`; `addi x2,x1,5`; `add x3,x1,x2`, each valid for one edge → x1=5, x2=10, x3=15, x0=0, PC=12.
- Then `and x4,x2,x3` encoded with funct7=0100000 → x4=10 (0xA), PC=16.
- `beq x2,x4,+2` (x2=x4=10) from PC=16 → PC=18. `bne x0,x4,+4` from 18 → PC=22.
- `blt x0,x4,+2` → PC+2. `bge x4,x0,+4` → PC+4. `bltu x4,x0,+4` → not taken, PC+4.
- `jal x8,+34` at PC=P → x8=P+4, PC=P+34. Then `jalr x9,5(x1)` → x9=PC+4, PC=(5+5)&~1=10.
- Hold valid=0 for 4 edges → no state change. Assert `cpu_rst` low mid-sequence → PC=0 and all registers 0 without waiting for a clock edge. `addi x0,x0,7` → x0 stays 0.
